// File: rtl/id_stage_if.sv
// Fetch/register-file/write-back/execute signal bundle around the decode stage.
// Ports: slave = id_stage view, master = surrounding pipeline view.
interface id_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic [4:0]  readAddr1;
    logic [4:0]  readAddr2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [3:0]  ex_alu_op;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic        ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, rs1_data, rs2_data,
        input  wb_we, wb_addr, wb_data, flush, ex_ready,
        output id_ready, readAddr1, readAddr2, ex_valid, ex_pc,
        output ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd,
        output ex_imm, ex_alu_op, ex_reg_write, ex_mem_read,
        output ex_mem_write, ex_branch, ex_jump, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, rs1_data, rs2_data,
        output wb_we, wb_addr, wb_data, flush, ex_ready,
        input  id_ready, readAddr1, readAddr2, ex_valid, ex_pc,
        input  ex_rs1_data, ex_rs2_data, ex_rs1, ex_rs2, ex_rd,
        input  ex_imm, ex_alu_op, ex_reg_write, ex_mem_read,
        input  ex_mem_write, ex_branch, ex_jump, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register read with write-back bypass, decode, ID/EX register.
// Ports: clk, reset (async, active-high), bus (id_stage_if.slave).
module id_stage (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_ex_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.readAddr1 = rs1;
    assign bus.readAddr2 = rs2;

    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        writes;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic        use1;
    logic        use2;

    always_comb begin
        imm       = '0;
        alu_op    = '0;
        writes    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        use1      = 1'b0;
        use2      = 1'b0;
        unique case (opcode)
            OP_LUI, OP_AUIPC: begin
                imm    = {instr[31:12], 12'b0};
                writes = 1'b1;
            end
            OP_JAL: begin
                imm    = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
                writes = 1'b1;
                jump   = 1'b1;
            end
            OP_JALR: begin
                imm    = {{20{instr[31]}}, instr[31:20]};
                writes = 1'b1;
                jump   = 1'b1;
                use1   = 1'b1;
            end
            OP_BRANCH: begin
                imm    = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
                alu_op = {1'b0, f3};
                branch = 1'b1;
                use1   = 1'b1;
                use2   = 1'b1;
            end
            OP_LOAD: begin
                imm      = {{20{instr[31]}}, instr[31:20]};
                writes   = 1'b1;
                mem_read = 1'b1;
                use1     = 1'b1;
            end
            OP_STORE: begin
                imm       = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                mem_write = 1'b1;
                use1      = 1'b1;
                use2      = 1'b1;
            end
            OP_IMM: begin
                imm    = {{20{instr[31]}}, instr[31:20]};
                // funct7[5] only selects SRAI; elsewhere it is immediate bits
                alu_op = {(f3 == 3'b101) & instr[30], f3};
                writes = 1'b1;
                use1   = 1'b1;
            end
            OP_OP: begin
                alu_op = {instr[30], f3};
                writes = 1'b1;
                use1   = 1'b1;
                use2   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // x0 reads 0; same-cycle write-back wins over the register file
    function automatic logic [31:0] operand(
        input logic [4:0]  a,
        input logic [31:0] rf,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] wd
    );
        if (a == 5'd0)
            return 32'd0;
        else if (we && wa == a)
            return wd;
        else
            return rf;
    endfunction

    id_ex_t q;
    id_ex_t d;
    logic   reg_write;
    logic   hazard;

    assign reg_write = writes && (rd != 5'd0);

    always_comb begin
        d           = '0;
        d.valid     = bus.if_valid;
        d.pc        = bus.if_pc;
        d.rs1_data  = operand(rs1, bus.rs1_data, bus.wb_we,
                              bus.wb_addr, bus.wb_data);
        d.rs2_data  = operand(rs2, bus.rs2_data, bus.wb_we,
                              bus.wb_addr, bus.wb_data);
        d.rs1       = use1 ? rs1 : 5'd0;
        d.rs2       = use2 ? rs2 : 5'd0;
        d.rd        = reg_write ? rd : 5'd0;
        d.imm       = imm;
        d.alu_op    = alu_op;
        // an empty slot must never carry side-effecting control
        d.reg_write = reg_write & bus.if_valid;
        d.mem_read  = mem_read  & bus.if_valid;
        d.mem_write = mem_write & bus.if_valid;
        d.branch    = branch    & bus.if_valid;
        d.jump      = jump      & bus.if_valid;
        d.illegal   = illegal   & bus.if_valid;
    end

    assign hazard = q.valid && q.mem_read && (q.rd != 5'd0)
                 && bus.if_valid
                 && ((use1 && q.rd == rs1) || (use2 && q.rd == rs2));

    assign bus.id_ready = !bus.flush && bus.ex_ready && !hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (bus.flush || (bus.ex_ready && hazard)) begin
            q.valid     <= 1'b0;
            q.reg_write <= 1'b0;
            q.mem_read  <= 1'b0;
            q.mem_write <= 1'b0;
            q.branch    <= 1'b0;
            q.jump      <= 1'b0;
            q.illegal   <= 1'b0;
        end else if (bus.ex_ready) begin
            q <= d;
        end
    end

    assign bus.ex_valid     = q.valid;
    assign bus.ex_pc        = q.pc;
    assign bus.ex_rs1_data  = q.rs1_data;
    assign bus.ex_rs2_data  = q.rs2_data;
    assign bus.ex_rs1       = q.rs1;
    assign bus.ex_rs2       = q.rs2;
    assign bus.ex_rd        = q.rd;
    assign bus.ex_imm       = q.imm;
    assign bus.ex_alu_op    = q.alu_op;
    assign bus.ex_reg_write = q.reg_write;
    assign bus.ex_mem_read  = q.mem_read;
    assign bus.ex_mem_write = q.mem_write;
    assign bus.ex_branch    = q.branch;
    assign bus.ex_jump      = q.jump;
    assign bus.ex_illegal   = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed RV32I words with hand-computed decodes.
// Issued words push expectations; a negedge monitor pops them on each EX transfer.
module tb_id_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    id_stage_if bus ();

    id_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pc, rs1_data, rs2_data, rs1, rs2, rd, imm, alu_op,
    // {reg_write, mem_read, mem_write, branch, jump, illegal}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [5:0]  ctl;
    } exp_t;

    exp_t  sb[$];
    string nq[$];

    function automatic exp_t mk(
        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
        input logic [31:0] imm, input logic [3:0] alu, input logic [5:0] ctl
    );
        return {pc, a, b, r1, r2, rd, imm, alu, ctl};
    endfunction

    function automatic exp_t cur();
        return {bus.ex_pc, bus.ex_rs1_data, bus.ex_rs2_data,
                bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_imm,
                bus.ex_alu_op,
                {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write,
                 bus.ex_branch, bus.ex_jump, bus.ex_illegal}};
    endfunction

    task automatic chk_e(input string n, input exp_t a, input exp_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic chk_w(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %h want %h", n, a, e);
        end
    endtask

    task automatic chk_b(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %b want %b", n, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.ex_valid && bus.ex_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue got %h want none", cur());
            end else begin
                chk_e(nq.pop_front(), cur(), sb.pop_front());
            end
        end
    end

    task automatic drive(
        input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic we, input logic [4:0] wa, input logic [31:0] wd
    );
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.wb_we    = 1'b0;
    endtask

    task automatic issue(
        input string n, input logic [31:0] ins, input logic [31:0] pc,
        input logic [31:0] r1, input logic [31:0] r2,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input exp_t e
    );
        drive(ins, pc, r1, r2, we, wa, wd);
        #1;
        chk_b({n, "_id_ready"}, bus.id_ready, 1'b1);
        sb.push_back(e);
        nq.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        idle();
        #1;
        chk_b("reset_valid", bus.ex_valid, 1'b0);
        chk_w("reset_imm", bus.ex_imm, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_b("post_reset_ready", bus.id_ready, 1'b1);

        issue("addi", 32'hFFC08293, 32'h100, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0,
              mk(32'h100, 32'd10, 32'd0, 5'd1, 5'd0, 5'd5,
                 32'hFFFFFFFC, 4'b0000, 6'b100000));
        issue("add_byp", 32'h002081B3, 32'h104, 32'h22, 32'h11,
              1'b1, 5'd2, 32'h55,
              mk(32'h104, 32'h22, 32'h55, 5'd1, 5'd2, 5'd3,
                 32'd0, 4'b0000, 6'b100000));
        issue("add_x0wb", 32'h002081B3, 32'h108, 32'h22, 32'h11,
              1'b1, 5'd0, 32'h55,
              mk(32'h108, 32'h22, 32'h11, 5'd1, 5'd2, 5'd3,
                 32'd0, 4'b0000, 6'b100000));
        issue("sub_byp1", 32'h40310233, 32'h10C, 32'h20, 32'h30,
              1'b1, 5'd2, 32'h99,
              mk(32'h10C, 32'h99, 32'h30, 5'd2, 5'd3, 5'd4,
                 32'd0, 4'b1000, 6'b100000));
        issue("srai", 32'h4030D093, 32'h110, 32'h80, 32'd0, 1'b0, 5'd0, 32'd0,
              mk(32'h110, 32'h80, 32'd0, 5'd1, 5'd0, 5'd1,
                 32'h00000403, 4'b1101, 6'b100000));
        issue("sw", 32'h0020A423, 32'h114, 32'h1000, 32'h77,
              1'b0, 5'd0, 32'd0,
              mk(32'h114, 32'h1000, 32'h77, 5'd1, 5'd2, 5'd0,
                 32'd8, 4'b0000, 6'b001000));
        issue("bne", 32'hFE209CE3, 32'h118, 32'd5, 32'd6, 1'b0, 5'd0, 32'd0,
              mk(32'h118, 32'd5, 32'd6, 5'd1, 5'd2, 5'd0,
                 32'hFFFFFFF8, 4'b0001, 6'b000100));
        issue("lui", 32'h12345537, 32'h11C, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              mk(32'h11C, 32'd0, 32'd0, 5'd0, 5'd0, 5'd10,
                 32'h12345000, 4'b0000, 6'b100000));
        issue("jal", 32'h010000EF, 32'h120, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0,
              mk(32'h120, 32'd0, 32'd0, 5'd0, 5'd0, 5'd1,
                 32'h00000010, 4'b0000, 6'b100010));
        issue("illegal", 32'h0000007F, 32'h124, 32'd0, 32'd0,
              1'b0, 5'd0, 32'd0,
              mk(32'h124, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0,
                 32'd0, 4'b0000, 6'b000001));
        issue("lw", 32'h0000A303, 32'h128, 32'h2000, 32'd0,
              1'b0, 5'd0, 32'd0,
              mk(32'h128, 32'h2000, 32'd0, 5'd1, 5'd0, 5'd6,
                 32'd0, 4'b0000, 6'b110000));

        drive(32'h001303B3, 32'h12C, 32'h66, 32'h1, 1'b0, 5'd0, 32'd0);
        #1;
        chk_b("loaduse_stall_ready", bus.id_ready, 1'b0);
        @(posedge clk);
        #1;
        chk_b("loaduse_bubble_valid", bus.ex_valid, 1'b0);
        chk_b("loaduse_bubble_rw", bus.ex_reg_write, 1'b0);
        chk_b("loaduse_bubble_mr", bus.ex_mem_read, 1'b0);
        issue("add_after_lw", 32'h001303B3, 32'h12C, 32'h66, 32'h1,
              1'b0, 5'd0, 32'd0,
              mk(32'h12C, 32'h66, 32'h1, 5'd6, 5'd1, 5'd7,
                 32'd0, 4'b0000, 6'b100000));

        drive(32'hFFC08293, 32'h130, 32'd10, 32'd0, 1'b0, 5'd0, 32'd0);
        @(posedge clk);
        #1;
        bus.ex_ready = 1'b0;
        drive(32'h0020A423, 32'h134, 32'h1000, 32'h77, 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_b("stall_valid", bus.ex_valid, 1'b1);
            chk_b("stall_ready", bus.id_ready, 1'b0);
            chk_e("stall_hold", cur(),
                  mk(32'h130, 32'd10, 32'd0, 5'd1, 5'd0, 5'd5,
                     32'hFFFFFFFC, 4'b0000, 6'b100000));
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        #1;
        chk_b("flush_ready", bus.id_ready, 1'b0);
        @(posedge clk);
        #1;
        chk_b("flush_valid", bus.ex_valid, 1'b0);
        chk_b("flush_rw", bus.ex_reg_write, 1'b0);
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        idle();
        @(posedge clk);
        #1;

        issue("addi_pre_rst", 32'hFFC08293, 32'h140, 32'd3, 32'd0,
              1'b0, 5'd0, 32'd0,
              mk(32'h140, 32'd3, 32'd0, 5'd1, 5'd0, 5'd5,
                 32'hFFFFFFFC, 4'b0000, 6'b100000));
        idle();
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk_b("async_rst_valid", bus.ex_valid, 1'b0);
        chk_w("async_rst_imm", bus.ex_imm, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk_b("rst_release_ready", bus.id_ready, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_w("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline, sitting between fetch and execute. Drives the register file's two read addresses, captures the returned operands with write-back bypass, and decodes the instruction into control fields. Results are registered into the ID/EX pipeline register. Handles the load-use interlock, downstream back-pressure and branch flush.

## Interface
- No parameters. Fixed: XLEN 32, 5-bit register addresses.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- if_valid  in  1  fetch presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- id_ready  out  1  stage accepts the fetch word this cycle
- readAddr1  out  5  register-file port 1 address, = if_instr[19:15]
- readAddr2  out  5  register-file port 2 address, = if_instr[24:20]
- rs1_data  in  32  register-file port 1 data, combinational, x0 reads 0
- rs2_data  in  32  register-file port 2 data
- wb_we  in  1  write-back enable, same signal as the register file's writeEnable
- wb_addr  in  5  write-back address
- wb_data  in  32  write-back data
- flush  in  1  taken branch/jump resolved in EX; kill the ID/EX contents
- ex_ready  in  1  execute stage accepts the ID/EX contents
- ex_valid  out  1  ID/EX holds a live instruction
- ex_pc  out  32  PC of that instruction
- ex_rs1_data  out  32  operand 1
- ex_rs2_data  out  32  operand 2
- ex_rs1  out  5  rs1 address; 0 if the format has no rs1
- ex_rs2  out  5  rs2 address; 0 if the format has no rs2
- ex_rd  out  5  destination register; 0 if there is no write
- ex_imm  out  32  sign-extended immediate
- ex_alu_op  out  4  ALU operation code
- ex_reg_write  out  1  instruction writes rd
- ex_mem_read  out  1  load
- ex_mem_write  out  1  store
- ex_branch  out  1  conditional branch
- ex_jump  out  1  JAL/JALR
- ex_illegal  out  1  unrecognised opcode

## Operation
- Opcodes and format decode:
  - LUI 0110111: U-type
  - AUIPC 0010111: U-type
  - JAL 1101111: J-type
  - JALR 1100111: I-type
  - BRANCH 1100011: B-type
  - LOAD 0000011: I-type
  - STORE 0100011: S-type
  - OP-IMM 0010011: I-type
  - OP 0110011: R-type
  - Any other opcode: ex_illegal=1, all control bits 0, rd=0.
- Immediates follow the RISC-V spec for I/S/B/U/J, sign-extended from bit 31; U-type imm = {instr[31:12], 12'b0}. R-type imm = 0.
- ex_alu_op:
  - OP: {funct7[5], funct3}
  - OP-IMM: {funct3==101 ? funct7[5] : 0, funct3}
  - BRANCH: {0, funct3}
  - all other opcodes: 0000 (ADD)
- ex_reg_write = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP when rd != 0; otherwise rd is forced to 0.
- Write-back bypass: when wb_we=1, wb_addr != 0 and wb_addr == readAddrN, operand N takes wb_data instead of rsN_data. x0 is always 0.
- Load-use hazard condition, all of:
  - ex_valid, ex_mem_read, ex_rd != 0
  - ex_rd equals a source register the current instruction actually uses
  - if_valid
- Cycle update priority, highest first:
  1. reset: ex_valid=0, all ex_* outputs 0.
  2. flush: ex_valid=0; control bits cleared. Fetch word not consumed (id_ready=0); fetch re-steers.
  3. ex_ready=0: ID/EX holds every field; id_ready=0.
  4. Load-use hazard: bubble inserted (ex_valid=0, control bits 0); id_ready=0 so the same fetch word is re-decoded next cycle.
  5. Otherwise: ID/EX loads the decode of if_instr with ex_valid=if_valid; id_ready=1.
- A bubble or invalid entry never asserts ex_reg_write, ex_mem_read or ex_mem_write.

## Timing
- Latency 1 cycle: a word accepted at edge N appears on ex_* after edge N.
- id_ready is combinational from flush, ex_ready and the hazard logic. Fetch advances only on if_valid & id_ready.
- Load-use costs exactly 1 bubble cycle. The next cycle the load has moved on and the bypass or EX forwarding supplies the value.
- Reset asserted mid-stream clears ID/EX immediately (asynchronous). First capture occurs on the first rising edge after deassertion.
- flush together with ex_ready=0: flush wins, and ex_valid falls.

## Test plan
- Reset: assert reset with ex_valid=1 mid-cycle -> ex_valid=0 and ex_imm=0 asynchronously; id_ready=1 after release.
- ADDI x5,x1,-4 (0xFFC08293) with rs1_data=10 -> next cycle: ex_rd=5, ex_imm=0xFFFFFFFC, ex_alu_op=0000, ex_rs1_data=10, ex_reg_write=1.
- Bypass: ADD x3,x1,x2 with wb_we=1, wb_addr=2, wb_data=0x55, rs2_data=0x11 -> ex_rs2_data=0x55. Same stimulus with wb_addr=0 -> 0x11.
- Load-use: LW x6 in EX, then ADD x7,x6,x1 offered -> one cycle with id_ready=0 and ex_valid=0, then the ADD is issued with ex_valid=1.
- Back-pressure and flush: ex_ready=0 for 3 cycles -> ex_* fields stable. Then flush=1 -> ex_valid=0 next edge, id_ready=0 during the flush cycle.
- Illegal word 0x0000007F -> ex_illegal=1, ex_reg_write=0, ex_mem_write=0.
